// File: rtl/rs_pkg.sv
// Shared types for the wakeup reservation station: default widths, ALU control
// encodings and the entry/payload layouts held in each slot.
package rs_pkg;

   localparam int RS_TAG_W  = 6;
   localparam int RS_DATA_W = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_ctrl_e;

   // Field order here is the bit order of each issue_payload lane, MSB first.
   typedef struct packed {
      logic                 is_ls;
      logic                 alusrc;
      logic [3:0]           alu_ctrl;
      logic [RS_TAG_W-1:0]  rd_tag;
      logic [RS_DATA_W-1:0] rs1_val;
      logic [RS_DATA_W-1:0] rs2_val;
      logic [RS_DATA_W-1:0] imm;
      logic [RS_TAG_W-1:0]  rob_num;
   } rs_payload_t;

   typedef struct packed {
      rs_payload_t         pl;
      logic [RS_TAG_W-1:0] rs1_tag;
      logic [RS_TAG_W-1:0] rs2_tag;
      logic                rs1_rdy;
      logic                rs2_rdy;
   } rs_entry_t;

endpackage

// File: rtl/wakeup_reservation_station_if.sv
// Dispatch, result-broadcast and issue signals of the reservation station.
// master drives dispatch/CDB/FU status, slave is the station itself.
interface wakeup_reservation_station_if #(
   parameter int DEPTH   = 16,
   parameter int NUM_FU  = 3,
   parameter int NUM_CDB = 2,
   parameter int TAG_W   = 6,
   parameter int DATA_W  = 32
);
   localparam int PW = 6 + 2*TAG_W + 3*DATA_W;
   localparam int CW = $clog2(DEPTH) + 1;

   logic                      disp_valid;
   logic                      disp_ready;
   logic [TAG_W-1:0]          disp_rd_tag;
   logic [TAG_W-1:0]          disp_rs1_tag;
   logic [TAG_W-1:0]          disp_rs2_tag;
   logic [TAG_W-1:0]          disp_rob_num;
   logic [DATA_W-1:0]         disp_rs1_val;
   logic [DATA_W-1:0]         disp_rs2_val;
   logic [DATA_W-1:0]         disp_imm;
   logic                      disp_rs1_rdy;
   logic                      disp_rs2_rdy;
   logic [3:0]                disp_alu_ctrl;
   logic                      disp_is_ls;
   logic                      disp_alusrc;
   logic [NUM_CDB-1:0]        cdb_valid;
   logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
   logic [NUM_CDB*DATA_W-1:0] cdb_val;
   logic                      flush;
   logic [NUM_FU-1:0]         fu_ready;
   logic [NUM_FU-1:0]         issue_valid;
   logic [NUM_FU*PW-1:0]      issue_payload;
   logic [CW-1:0]             count;
   logic                      empty;

   modport master (
      output disp_valid, disp_rd_tag, disp_rs1_tag, disp_rs2_tag, disp_rob_num,
             disp_rs1_val, disp_rs2_val, disp_imm, disp_rs1_rdy, disp_rs2_rdy,
             disp_alu_ctrl, disp_is_ls, disp_alusrc,
             cdb_valid, cdb_tag, cdb_val, flush, fu_ready,
      input  disp_ready, issue_valid, issue_payload, count, empty
   );

   modport slave (
      input  disp_valid, disp_rd_tag, disp_rs1_tag, disp_rs2_tag, disp_rob_num,
             disp_rs1_val, disp_rs2_val, disp_imm, disp_rs1_rdy, disp_rs2_rdy,
             disp_alu_ctrl, disp_is_ls, disp_alusrc,
             cdb_valid, cdb_tag, cdb_val, flush, fu_ready,
      output disp_ready, issue_valid, issue_payload, count, empty
   );

endinterface

// File: rtl/rs_age_select.sv
// Picks the oldest candidate: an entry wins when no other candidate is older.
// age[j][i] = 1 means slot j is older than slot i.
module rs_age_select #(
   parameter int DEPTH = 16
) (
   input  logic [DEPTH-1:0]            eligible,
   input  logic [DEPTH-1:0][DEPTH-1:0] age,
   input  logic [DEPTH-1:0]            excl,
   output logic [DEPTH-1:0]            grant
);

   logic [DEPTH-1:0] cand;
   logic [DEPTH-1:0] blocked;

   always_comb begin
      cand    = eligible & ~excl;
      blocked = '0;
      grant   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (cand[j] && age[j][i]) blocked[i] = 1'b1;
         end
         grant[i] = cand[i] & ~blocked[i];
      end
   end

endmodule

// File: rtl/wakeup_reservation_station.sv
// Unified reservation station: CDB wakeup with dispatch bypass, age-matrix
// oldest-first selection across NUM_FU issue ports, registered issue.
module wakeup_reservation_station
   import rs_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int NUM_FU  = 3,
   parameter int NUM_CDB = 2,
   parameter int TAG_W   = RS_TAG_W,
   parameter int DATA_W  = RS_DATA_W
) (
   input  logic clk,
   input  logic reset,
   wakeup_reservation_station_if.slave rs
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int PW = $bits(rs_payload_t);

   logic [DEPTH-1:0]            valid_q;
   rs_entry_t                   entry_q [DEPTH];
   rs_entry_t                   entry_d [DEPTH];
   logic [DEPTH-1:0][DEPTH-1:0] age_q;
   logic [CW-1:0]               count_q;
   logic [NUM_FU-1:0]           issue_valid_q;
   rs_payload_t                 issue_pl_q [NUM_FU];
   rs_payload_t                 sel_pl [NUM_FU];

   logic                        disp_ready;
   logic                        disp_fire;
   logic [DEPTH-1:0]            alloc_oh;
   logic [DEPTH-1:0]            eligible;
   logic [DEPTH-1:0]            issued;
   logic [DEPTH-1:0]            grant [NUM_FU];
   logic [DEPTH-1:0]            excl [NUM_FU+1];
   logic [CW-1:0]               n_issued;
   rs_entry_t                   disp_entry;
   logic [NUM_FU*PW-1:0]        issue_payload_flat;

   assign disp_ready = (count_q < CW'(DEPTH));
   assign disp_fire  = rs.disp_valid && disp_ready && !rs.flush;
   // Lowest clear bit of the valid mask is the allocation target.
   assign alloc_oh   = disp_fire ? (~valid_q & (valid_q + DEPTH'(1))) : '0;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < DEPTH; i++) begin
         eligible[i] = valid_q[i] && entry_q[i].rs1_rdy && entry_q[i].rs2_rdy;
      end
   end

   assign excl[0] = '0;
   for (genvar k = 0; k < NUM_FU; k++) begin : g_fu
      rs_age_select #(.DEPTH(DEPTH)) u_sel (
         .eligible (eligible & {DEPTH{rs.fu_ready[k]}}),
         .age      (age_q),
         .excl     (excl[k]),
         .grant    (grant[k])
      );
      assign excl[k+1] = excl[k] | grant[k];
   end
   assign issued = excl[NUM_FU];

   always_comb begin
      n_issued = '0;
      for (int i = 0; i < DEPTH; i++) n_issued = n_issued + CW'(issued[i]);
   end

   always_comb begin
      for (int k = 0; k < NUM_FU; k++) begin
         sel_pl[k] = '0;
         for (int i = 0; i < DEPTH; i++) begin
            if (grant[k][i]) sel_pl[k] = entry_q[i].pl;
         end
      end
   end

   // New entry, with operands picked off a same-cycle broadcast.
   always_comb begin
      disp_entry             = '0;
      disp_entry.pl.is_ls    = rs.disp_is_ls;
      disp_entry.pl.alusrc   = rs.disp_alusrc;
      disp_entry.pl.alu_ctrl = rs.disp_alu_ctrl;
      disp_entry.pl.rd_tag   = rs.disp_rd_tag;
      disp_entry.pl.rs1_val  = rs.disp_rs1_val;
      disp_entry.pl.rs2_val  = rs.disp_rs2_val;
      disp_entry.pl.imm      = rs.disp_imm;
      disp_entry.pl.rob_num  = rs.disp_rob_num;
      disp_entry.rs1_tag     = rs.disp_rs1_tag;
      disp_entry.rs2_tag     = rs.disp_rs2_tag;
      disp_entry.rs1_rdy     = rs.disp_rs1_rdy;
      disp_entry.rs2_rdy     = rs.disp_rs2_rdy;
      for (int c = 0; c < NUM_CDB; c++) begin
         if (rs.cdb_valid[c] && !rs.disp_rs1_rdy && rs.cdb_tag[c*TAG_W +: TAG_W] == rs.disp_rs1_tag) begin
            disp_entry.rs1_rdy    = 1'b1;
            disp_entry.pl.rs1_val = rs.cdb_val[c*DATA_W +: DATA_W];
         end
         if (rs.cdb_valid[c] && !rs.disp_rs2_rdy && rs.cdb_tag[c*TAG_W +: TAG_W] == rs.disp_rs2_tag) begin
            disp_entry.rs2_rdy    = 1'b1;
            disp_entry.pl.rs2_val = rs.cdb_val[c*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         entry_d[i] = entry_q[i];
         for (int c = 0; c < NUM_CDB; c++) begin
            if (valid_q[i] && rs.cdb_valid[c] && !entry_q[i].rs1_rdy &&
                rs.cdb_tag[c*TAG_W +: TAG_W] == entry_q[i].rs1_tag) begin
               entry_d[i].rs1_rdy    = 1'b1;
               entry_d[i].pl.rs1_val = rs.cdb_val[c*DATA_W +: DATA_W];
            end
            if (valid_q[i] && rs.cdb_valid[c] && !entry_q[i].rs2_rdy &&
                rs.cdb_tag[c*TAG_W +: TAG_W] == entry_q[i].rs2_tag) begin
               entry_d[i].rs2_rdy    = 1'b1;
               entry_d[i].pl.rs2_val = rs.cdb_val[c*DATA_W +: DATA_W];
            end
         end
         if (alloc_oh[i]) entry_d[i] = disp_entry;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q       <= '0;
         age_q         <= '0;
         count_q       <= '0;
         issue_valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
         for (int k = 0; k < NUM_FU; k++) issue_pl_q[k] <= '0;
      end else if (rs.flush) begin
         valid_q       <= '0;
         count_q       <= '0;
         issue_valid_q <= '0;
      end else begin
         valid_q <= (valid_q & ~issued) | alloc_oh;
         count_q <= count_q + CW'(disp_fire) - n_issued;
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
         // Newcomer is younger than every entry currently held.
         for (int i = 0; i < DEPTH; i++) begin
            if (alloc_oh[i]) begin
               for (int j = 0; j < DEPTH; j++) begin
                  age_q[i][j] <= 1'b0;
                  age_q[j][i] <= valid_q[j];
               end
            end
         end
         for (int k = 0; k < NUM_FU; k++) begin
            issue_valid_q[k] <= |grant[k];
            if (|grant[k]) issue_pl_q[k] <= sel_pl[k];
         end
      end
   end

   always_comb begin
      issue_payload_flat = '0;
      for (int k = 0; k < NUM_FU; k++) issue_payload_flat[k*PW +: PW] = issue_pl_q[k];
   end

   assign rs.disp_ready    = disp_ready;
   assign rs.count         = count_q;
   assign rs.empty         = (count_q == '0);
   assign rs.issue_valid   = issue_valid_q;
   assign rs.issue_payload = issue_payload_flat;

endmodule

// File: tb/tb_wakeup_reservation_station.sv
// Directed bench for wakeup_reservation_station with an issue scoreboard.
module tb_wakeup_reservation_station;
   import rs_pkg::*;

   localparam int DEPTH = 16, NUM_FU = 3, NUM_CDB = 2, TAG_W = 6, DATA_W = 32;
   localparam int PW = $bits(rs_payload_t);

   typedef struct {
      int          fu;
      rs_payload_t pl;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   wakeup_reservation_station_if #(.DEPTH(DEPTH), .NUM_FU(NUM_FU), .NUM_CDB(NUM_CDB),
                                   .TAG_W(TAG_W), .DATA_W(DATA_W)) rs_if ();

   wakeup_reservation_station #(.DEPTH(DEPTH), .NUM_FU(NUM_FU), .NUM_CDB(NUM_CDB),
                                .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .rs    (rs_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic rs_payload_t mk(input logic [5:0] rob, input logic [31:0] v1, input logic [31:0] v2);
      rs_payload_t p;
      p.is_ls    = rob[0];
      p.alusrc   = rob[1];
      p.alu_ctrl = rob[5:2];
      p.rd_tag   = rob ^ 6'h2a;
      p.rs1_val  = v1;
      p.rs2_val  = v2;
      p.imm      = 32'h1000 | 32'(rob);
      p.rob_num  = rob;
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int fu, input rs_payload_t pl);
      exp_t e;
      e.fu = fu;
      e.pl = pl;
      exp_q.push_back(e);
   endtask

   task automatic disp(input logic [5:0] rob, input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                       input logic [5:0] t2, input logic r2, input logic [31:0] v2);
      rs_payload_t p;
      p = mk(rob, v1, v2);
      rs_if.disp_is_ls    = p.is_ls;
      rs_if.disp_alusrc   = p.alusrc;
      rs_if.disp_alu_ctrl = p.alu_ctrl;
      rs_if.disp_rd_tag   = p.rd_tag;
      rs_if.disp_rs1_val  = p.rs1_val;
      rs_if.disp_rs2_val  = p.rs2_val;
      rs_if.disp_imm      = p.imm;
      rs_if.disp_rob_num  = p.rob_num;
      rs_if.disp_rs1_tag  = t1;
      rs_if.disp_rs1_rdy  = r1;
      rs_if.disp_rs2_tag  = t2;
      rs_if.disp_rs2_rdy  = r2;
      rs_if.disp_valid    = 1'b1;
      tick();
      rs_if.disp_valid    = 1'b0;
   endtask

   // Every issued lane must match the head of the scoreboard, in FU order.
   always @(negedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_FU; k++) begin
            if (rs_if.issue_valid[k]) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_issue", 128'(rs_if.issue_valid[k]), 128'(0));
               end else begin
                  mon_e = exp_q.pop_front();
                  chk("issue_fu", 128'(k), 128'(mon_e.fu));
                  chk("issue_payload", 128'(rs_if.issue_payload[k*PW +: PW]), 128'(mon_e.pl));
               end
            end
         end
      end
   end

   initial begin
      reset = 1'b0;
      rs_if.disp_valid = 1'b0; rs_if.disp_rd_tag = '0; rs_if.disp_rs1_tag = '0;
      rs_if.disp_rs2_tag = '0; rs_if.disp_rob_num = '0; rs_if.disp_rs1_val = '0;
      rs_if.disp_rs2_val = '0; rs_if.disp_imm = '0; rs_if.disp_rs1_rdy = 1'b0;
      rs_if.disp_rs2_rdy = 1'b0; rs_if.disp_alu_ctrl = '0; rs_if.disp_is_ls = 1'b0;
      rs_if.disp_alusrc = 1'b0; rs_if.cdb_valid = '0; rs_if.cdb_tag = '0;
      rs_if.cdb_val = '0; rs_if.flush = 1'b0; rs_if.fu_ready = '0;
      #2;
      chk("rst_count", 128'(rs_if.count), 128'(0));
      chk("rst_empty", 128'(rs_if.empty), 128'(1));
      chk("rst_issue_valid", 128'(rs_if.issue_valid), 128'(0));
      chk("rst_disp_ready", 128'(rs_if.disp_ready), 128'(1));
      chk("rst_payload_zero", 128'(|rs_if.issue_payload), 128'(0));
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      tick();

      // Wakeup: ready B overtakes waiting A, then A issues with the broadcast value.
      rs_if.fu_ready = 3'b001;
      disp(6'd1, 6'd5, 1'b0, 32'hBAD1, 6'd0, 1'b1, 32'h22);
      disp(6'd2, 6'd0, 1'b1, 32'h31, 6'd0, 1'b1, 32'h32);
      push(0, mk(6'd2, 32'h31, 32'h32));
      rs_if.cdb_valid = 2'b01;
      rs_if.cdb_tag   = {6'd0, 6'd5};
      rs_if.cdb_val   = {32'h0, 32'h1234};
      tick();
      rs_if.cdb_valid = '0;
      push(0, mk(6'd1, 32'h1234, 32'h22));
      chk("wake_count_mid", 128'(rs_if.count), 128'(1));
      repeat (2) tick();
      chk("wake_count_end", 128'(rs_if.count), 128'(0));

      // Oldest-first across three ports.
      rs_if.fu_ready = 3'b000;
      for (int i = 0; i < 4; i++) disp(6'(10 + i), 6'd0, 1'b1, 32'(100 + i), 6'd0, 1'b1, 32'(200 + i));
      chk("age_count4", 128'(rs_if.count), 128'(4));
      push(0, mk(6'd10, 32'd100, 32'd200));
      push(1, mk(6'd11, 32'd101, 32'd201));
      push(2, mk(6'd12, 32'd102, 32'd202));
      push(0, mk(6'd13, 32'd103, 32'd203));
      rs_if.fu_ready = 3'b111;
      tick();
      chk("age_issue_valid_1", 128'(rs_if.issue_valid), 128'(3'b111));
      chk("age_count_1", 128'(rs_if.count), 128'(1));
      tick();
      chk("age_issue_valid_2", 128'(rs_if.issue_valid), 128'(3'b001));
      chk("age_count_2", 128'(rs_if.count), 128'(0));
      tick();
      chk("age_issue_valid_3", 128'(rs_if.issue_valid), 128'(0));

      // Dispatch-time bypass from CDB lane 1; lane 0 carries an unrelated tag.
      rs_if.cdb_valid = 2'b11;
      rs_if.cdb_tag   = {6'd9, 6'd7};
      rs_if.cdb_val   = {32'hDEAD, 32'h7777};
      disp(6'd20, 6'd3, 1'b1, 32'h41, 6'd9, 1'b0, 32'hBAD2);
      rs_if.cdb_valid = '0;
      push(0, mk(6'd20, 32'h41, 32'hDEAD));
      tick();
      chk("bypass_issue_valid", 128'(rs_if.issue_valid), 128'(3'b001));
      tick();

      // Fill to capacity with waiting entries.
      rs_if.fu_ready = 3'b000;
      for (int i = 0; i < DEPTH; i++) begin
         if (i == DEPTH - 1) chk("fill_ready_at_15", 128'(rs_if.disp_ready), 128'(1));
         disp(6'(32 + i), 6'd50, 1'b0, 32'h0, 6'd0, 1'b1, 32'h5);
      end
      chk("full_count", 128'(rs_if.count), 128'(16));
      chk("full_disp_ready", 128'(rs_if.disp_ready), 128'(0));
      chk("full_empty", 128'(rs_if.empty), 128'(0));
      disp(6'd60, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2);
      chk("full_extra_ignored", 128'(rs_if.count), 128'(16));
      rs_if.flush = 1'b1;
      tick();
      rs_if.flush = 1'b0;
      chk("flush_full_count", 128'(rs_if.count), 128'(0));
      chk("flush_full_ready", 128'(rs_if.disp_ready), 128'(1));
      rs_if.fu_ready  = 3'b111;
      rs_if.cdb_valid = 2'b01;
      rs_if.cdb_tag   = {6'd0, 6'd50};
      tick();
      rs_if.cdb_valid = '0;
      repeat (3) tick();

      // Flush beats a simultaneous dispatch and pending issue.
      rs_if.fu_ready = 3'b000;
      for (int i = 0; i < 8; i++) disp(6'(16 + i), 6'd0, 1'b1, 32'h9, 6'd0, 1'b1, 32'h8);
      chk("flush8_count_before", 128'(rs_if.count), 128'(8));
      rs_if.fu_ready = 3'b111;
      rs_if.flush    = 1'b1;
      disp(6'd63, 6'd0, 1'b1, 32'h3, 6'd0, 1'b1, 32'h4);
      rs_if.flush    = 1'b0;
      chk("flush8_count", 128'(rs_if.count), 128'(0));
      chk("flush8_empty", 128'(rs_if.empty), 128'(1));
      chk("flush8_issue_valid", 128'(rs_if.issue_valid), 128'(0));
      repeat (3) tick();
      chk("flush8_count_after", 128'(rs_if.count), 128'(0));

      // Asynchronous reset while full with issues pending.
      rs_if.fu_ready = 3'b000;
      for (int i = 0; i < DEPTH; i++) disp(6'(i), 6'd0, 1'b1, 32'(i), 6'd0, 1'b1, 32'h77);
      chk("rstmid_full_count", 128'(rs_if.count), 128'(16));
      rs_if.fu_ready = 3'b111;
      #2 reset = 1'b0;
      #1;
      chk("rstmid_count", 128'(rs_if.count), 128'(0));
      chk("rstmid_empty", 128'(rs_if.empty), 128'(1));
      chk("rstmid_issue_valid", 128'(rs_if.issue_valid), 128'(0));
      chk("rstmid_disp_ready", 128'(rs_if.disp_ready), 128'(1));
      chk("rstmid_payload_zero", 128'(|rs_if.issue_payload), 128'(0));
      tick();
      reset = 1'b1;
      repeat (4) tick();
      chk("rstmid_count_after", 128'(rs_if.count), 128'(0));

      chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wakeup_reservation_station.md
WAKEUP_RESERVATION_STATION -- requirements
Module: wakeup_reservation_station

Interface
REQ-001 SHALL have parameter DEPTH, 16, number of entries (power of 2, 4..64).
REQ-002 SHALL have parameter NUM_FU, 3, number of functional units / issue ports.
REQ-003 SHALL have parameter NUM_CDB, 2, number of result broadcast buses.
REQ-004 SHALL have parameters TAG_W, 6, physical/ROB tag width; DATA_W, 32, operand width.
REQ-005 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: disp_valid input 1, disp_ready output 1; dispatch handshake.
REQ-008 SHALL have ports: disp_rd_tag, disp_rs1_tag, disp_rs2_tag, disp_rob_num  input  TAG_W each.
REQ-009 SHALL have ports: disp_rs1_val, disp_rs2_val, disp_imm  input  DATA_W each; disp_rs1_rdy, disp_rs2_rdy  input  1 each.
REQ-010 SHALL have ports: disp_alu_ctrl input 4; disp_is_ls input 1; disp_alusrc input 1.
REQ-011 SHALL have ports: cdb_valid input NUM_CDB; cdb_tag input NUM_CDB*TAG_W; cdb_val input NUM_CDB*DATA_W; result broadcast.
REQ-012 SHALL have ports: flush input 1, discard all entries; fu_ready input NUM_FU, FU can accept this cycle.
REQ-013 SHALL have ports: issue_valid output NUM_FU; issue_payload output NUM_FU*(entry payload width) carrying is_ls, alusrc, alu_ctrl, rd_tag, rs1_val, rs2_val, imm, rob_num.
REQ-014 SHALL have ports: count output $clog2(DEPTH)+1 occupancy; empty output 1.

Function
REQ-015 disp_ready SHALL equal (count < DEPTH) from registered state; a slot freed by issue this cycle is not reusable this cycle.
REQ-016 On disp_valid && disp_ready && !flush, the lowest-index free slot SHALL be written and marked youngest among valid entries.
REQ-017 Each cycle, every valid entry with a not-ready source whose tag equals a valid cdb_tag SHALL capture that cdb_val and set the source ready at the edge.
REQ-018 At dispatch, a not-ready source matching a same-cycle valid CDB tag SHALL be written with the CDB value and ready=1 (bypass).
REQ-019 An entry SHALL be issue-eligible when valid, both sources ready in registered state, and not dispatched this cycle.
REQ-020 Selection SHALL be oldest-first: FU 0 takes the oldest eligible entry, FU k the oldest eligible entry not taken by FUs 0..k-1; only FUs with fu_ready=1 take entries.
REQ-021 Issue outputs SHALL be registered: selection in cycle N gives issue_valid[k]=1 and payload in cycle N+1; issued entries SHALL be invalidated at the same edge.
REQ-022 issue_valid[k] SHALL be 0 in any cycle following no selection for FU k; payload is don't-care when invalid.
REQ-023 count SHALL update by +dispatched -issued each cycle; simultaneous dispatch and issue SHALL be allowed.
REQ-024 flush SHALL invalidate all entries and zero issue_valid at the next edge, taking priority over dispatch, wakeup and issue.
REQ-025 Age ordering SHALL use a DEPTH x DEPTH older-than matrix; the row/column of a slot SHALL be rewritten on dispatch.

Reset
REQ-026 On reset low: all entries invalid, age matrix 0, count=0, empty=1, issue_valid=0, issue payload 0, disp_ready=1 after release.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight entries without issuing them.

Structure
REQ-028 Entry struct, TAG_W/DATA_W defaults and ALU control encodings SHALL live in shared package rs_pkg.
REQ-029 Oldest-eligible selection SHALL be sub-module rs_age_select (inputs: eligible mask, age matrix, exclusion mask; output: one-hot grant).

Verification
REQ-030 Dispatch A(rs1 tag 5 not ready), then B(ready), fu_ready=3'b001 -> B issues on FU0 first; CDB tag 5 value 0x1234 -> A issues next with rs1_val=0x1234.
REQ-031 Fill 16 entries, all not ready -> disp_ready=0 at count=16; extra disp_valid ignored, count stays 16.
REQ-032 Four ready entries dispatched in order E0..E3, fu_ready=3'b111 -> FU0=E0, FU1=E1, FU2=E2 same cycle; E3 issues next cycle.
REQ-033 Dispatch rs2 tag 9 not ready while cdb_tag 9 value 0xDEAD valid same cycle -> entry issues with rs2_val=0xDEAD without further broadcast.
REQ-034 8 entries valid, assert flush together with disp_valid -> next cycle count=0, empty=1, no issue_valid.
REQ-035 Reset low during full occupancy with issues pending -> all outputs at reset values immediately; no issue after release.
